// File: rtl/rgb_layer_arbiter.sv
// Two-stage RGB layer arbiter with frame counter and optional per-frame collision snapshot.
// Optional feature macro: RGB_ARB_COLLISION_EN (collision accumulator and snapshot handshake).
module rgb_layer_arbiter #(
    parameter int         NUM_LAYERS = 4,
    parameter logic [2:0] BG_COLOR   = 3'b000
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      vde_in,
    input  logic [NUM_LAYERS-1:0]     layer_on,
    input  logic [3*NUM_LAYERS-1:0]   layer_rgb,
    input  logic                      coll_ack,
    output logic                      hsync,
    output logic                      vsync,
    output logic                      vde,
    output logic [2:0]                rgb,
    output logic [7:0]                frame_cnt,
    output logic [NUM_LAYERS-1:0]     coll_flags,
    output logic                      coll_valid,
    output logic                      coll_overrun
);

    logic                    r_hs1;
    logic                    r_vs1;
    logic                    r_vde1;
    logic [NUM_LAYERS-1:0]   r_on1;
    logic [3*NUM_LAYERS-1:0] r_rgb1;
    logic                    r_s1_valid;
    logic                    r_vs_hist;
    logic                    r_hist_valid;

    logic [2:0]              w_pix;
    logic                    w_multi;
    logic                    w_frame_edge;

    // r_hist_valid keeps the first post-reset stage-1 sample from looking like a rising edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hs1        <= 1'b0;
            r_vs1        <= 1'b0;
            r_vde1       <= 1'b0;
            r_on1        <= '0;
            r_rgb1       <= '0;
            r_s1_valid   <= 1'b0;
            r_vs_hist    <= 1'b0;
            r_hist_valid <= 1'b0;
        end else begin
            r_hs1        <= hsync_in;
            r_vs1        <= vsync_in;
            r_vde1       <= vde_in;
            r_on1        <= layer_on;
            r_rgb1       <= layer_rgb;
            r_s1_valid   <= 1'b1;
            r_vs_hist    <= r_vs1;
            r_hist_valid <= r_s1_valid;
        end
    end

    assign w_frame_edge = r_vs1 & ~r_vs_hist & r_hist_valid;
    assign w_multi      = (r_on1 & (r_on1 - NUM_LAYERS'(1))) != '0;

    // Walk from the highest index down so the lowest set layer wins.
    always_comb begin
        w_pix = BG_COLOR;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (r_on1[i]) w_pix = r_rgb1[3*i +: 3];
        end
        if (!r_vde1) w_pix = 3'b000;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            hsync     <= 1'b0;
            vsync     <= 1'b0;
            vde       <= 1'b0;
            rgb       <= 3'b000;
            frame_cnt <= 8'd0;
        end else begin
            hsync <= r_hs1;
            vsync <= r_vs1;
            vde   <= r_vde1;
            rgb   <= w_pix;
            if (w_frame_edge) frame_cnt <= frame_cnt + 8'd1;
        end
    end

`ifdef RGB_ARB_COLLISION_EN
    logic [NUM_LAYERS-1:0] r_acc;
    logic                  w_coll_hit;

    assign w_coll_hit = r_vde1 & w_multi;

    // A collision pixel on the frame-edge cycle seeds the fresh accumulator.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_acc        <= '0;
            coll_flags   <= '0;
            coll_valid   <= 1'b0;
            coll_overrun <= 1'b0;
        end else begin
            if (w_frame_edge) begin
                r_acc      <= w_coll_hit ? r_on1 : '0;
                coll_flags <= r_acc;
                coll_valid <= 1'b1;
            end else begin
                if (w_coll_hit) r_acc <= r_acc | r_on1;
                if (coll_ack) coll_valid <= 1'b0;
            end
            if (coll_valid && coll_ack)
                coll_overrun <= 1'b0;
            else if (w_frame_edge && coll_valid)
                coll_overrun <= 1'b1;
        end
    end
`else
    logic w_unused_coll;

    assign w_unused_coll = coll_ack | w_multi;
    assign coll_flags    = '0;
    assign coll_valid    = 1'b0;
    assign coll_overrun  = 1'b0;
`endif

endmodule

// File: doc/rgb_layer_arbiter.md
RGB_LAYER_ARBITER -- requirements
Module: rgb_layer_arbiter

Interface
REQ-001 SHALL provide parameter NUM_LAYERS, default 4, the number of sprite/playfield requesters (2..8).
REQ-002 SHALL provide parameter BG_COLOR, default 3'b000, the 3-bit colour output when no layer is on during active video.
REQ-003 SHALL have port clk  input  1  the pixel clock; the only clock.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port hsync_in, vsync_in, vde_in  input  1 each  raw timing from the sync generator.
REQ-006 SHALL have port layer_on  input  NUM_LAYERS  per-layer pixel request; bit 0 has highest priority.
REQ-007 SHALL have port layer_rgb  input  3*NUM_LAYERS  per-layer colour; layer i is in bits [3i+2:3i], bit order {B,G,R}.
REQ-008 SHALL have port hsync, vsync, vde  output  1 each  timing aligned to rgb.
REQ-009 SHALL have port rgb  output  3  arbitrated 3-bit pixel colour.
REQ-010 SHALL have port frame_cnt  output  8  count of vsync_in rising edges.
REQ-011 SHALL have port coll_flags  output  NUM_LAYERS  per-layer collision snapshot of the last completed frame.
REQ-012 SHALL have port coll_valid  output  1  snapshot available; held until acknowledged.
REQ-013 SHALL have port coll_ack  input  1  consumer acknowledge of the snapshot.
REQ-014 SHALL have port coll_overrun  output  1  an unacknowledged snapshot was overwritten.

Function
REQ-015 SHALL register all inputs in stage 1 and produce registered outputs in stage 2; hsync, vsync, vde, rgb latency exactly 2 clk cycles, mutually aligned.
REQ-016 SHALL output rgb = layer_rgb of the lowest-index set layer_on bit when the stage-1 vde is 1.
REQ-017 SHALL output rgb = BG_COLOR when stage-1 vde is 1 and no layer_on bit is set.
REQ-018 SHALL output rgb = 3'b000 whenever stage-1 vde is 0, regardless of layer_on.
REQ-019 SHALL detect a vsync rising edge as stage-1 vsync = 1 with the previous stage-1 value = 0 (frame edge).
REQ-020 SHALL increment frame_cnt by 1 on each frame edge, wrapping 255 -> 0.
REQ-021 SHALL, on each stage-1 cycle with vde = 1 and two or more layer_on bits set, OR those set bits into an internal collision accumulator.
REQ-022 SHALL, on a frame edge, copy the accumulator to coll_flags, clear the accumulator, and set coll_valid to 1.
REQ-023 SHALL clear coll_valid on the cycle after coll_ack is sampled 1 with no frame edge in that cycle; coll_ack while coll_valid = 0 has no effect.
REQ-024 SHALL, on a frame edge while coll_valid = 1 and coll_ack = 0, overwrite coll_flags and set coll_overrun to 1.
REQ-025 SHALL, on a frame edge coinciding with coll_ack = 1, take the new snapshot, keep coll_valid = 1, and not set coll_overrun.
REQ-026 SHALL clear coll_overrun only when coll_ack is sampled 1 with coll_valid = 1.
REQ-027 SHALL let a collision pixel and a frame edge in the same cycle contribute to the new accumulator (set wins over clear).

Reset
REQ-028 SHALL, with reset_n sampled 0, drive hsync, vsync, vde = 0, rgb = 3'b000, frame_cnt = 0, coll_flags = 0, coll_valid = 0, coll_overrun = 0, clear both pipeline stages, the edge-detect history, and the accumulator.
REQ-029 SHALL, on reset asserted mid-frame, discard the partial accumulator; the first frame edge after release produces a snapshot covering only post-reset pixels.
REQ-030 SHALL not treat vsync_in = 1 in the first stage-1 cycle after reset as a frame edge.

Configuration
REQ-031 SHALL, with macro RGB_ARB_COLLISION_EN defined, implement REQ-021..REQ-027 as specified.
REQ-032 SHALL, without RGB_ARB_COLLISION_EN, omit the accumulator and snapshot logic, tie coll_flags, coll_valid, coll_overrun to 0, and ignore coll_ack; arbitration, timing, and frame_cnt are unchanged.

Verification
REQ-033 SHALL cover priority: vde_in = 1, layer_on = 4'b0110, layer1 = 3'b010, layer2 = 3'b100 -> rgb = 3'b010 two cycles later.
REQ-034 SHALL cover blanking: vde_in = 0, layer_on = 4'b1111 -> rgb = 3'b000 and vde = 0 two cycles later; no collision recorded.
REQ-035 SHALL cover collision: one active pixel with layer_on = 4'b0011, then a vsync_in rise -> coll_flags = 4'b0011, coll_valid = 1, frame_cnt +1.
REQ-036 SHALL cover overrun: two frame edges with no coll_ack -> coll_overrun = 1; then coll_ack = 1 -> coll_valid = 0 and coll_overrun = 0 next cycle.
REQ-037 SHALL cover wrap and reset: 256 frame edges -> frame_cnt = 0; reset_n = 0 for one cycle mid-frame with vsync_in held 1 -> all outputs 0 and no frame edge counted after release.
